// File: rtl/fpu_interco_pkg.sv
// Shared types and helpers for the FPU interconnect response path.
package fpu_interco_pkg;

  localparam int unsigned RESP_ID_W    = 9;
  localparam int unsigned RESP_DATA_W  = 32;
  localparam int unsigned RESP_FLAGS_W = 5;

  typedef struct packed {
    logic [RESP_DATA_W-1:0]  data;
    logic [RESP_FLAGS_W-1:0] flags;
    logic [RESP_ID_W-1:0]    id;
  } fpu_resp_t;

  // Credit counter must hold 0..depth inclusive.
  function automatic int unsigned credit_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fpu_resp_buffer_if.sv
// Request/grant and response signals between interconnect, FPU wrapper and consumer.
interface fpu_resp_buffer_if #(
  parameter int unsigned ID_WIDTH        = fpu_interco_pkg::RESP_ID_W,
  parameter int unsigned DATA_WIDTH      = fpu_interco_pkg::RESP_DATA_W,
  parameter int unsigned FLAGS_OUT_WIDTH = fpu_interco_pkg::RESP_FLAGS_W,
  parameter int unsigned DEPTH           = 4
);
  localparam int unsigned CW = fpu_interco_pkg::credit_width(DEPTH);

  logic                       req_i;
  logic                       gnt_o;
  logic                       fpu_req_o;
  logic                       fpu_gnt_i;
  logic                       fpu_rvalid_i;
  logic [DATA_WIDTH-1:0]      fpu_rdata_i;
  logic [FLAGS_OUT_WIDTH-1:0] fpu_rflags_i;
  logic [ID_WIDTH-1:0]        fpu_rID_i;
  logic                       rvalid_o;
  logic                       rready_i;
  logic [DATA_WIDTH-1:0]      rdata_o;
  logic [FLAGS_OUT_WIDTH-1:0] rflags_o;
  logic [ID_WIDTH-1:0]        rID_o;
  logic [CW-1:0]              credits_o;
  logic                       overflow_o;

  modport slave (
    input  req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rID_i, rready_i,
    output gnt_o, fpu_req_o, rvalid_o, rdata_o, rflags_o, rID_o, credits_o, overflow_o
  );

  modport master (
    output req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rID_i, rready_i,
    input  gnt_o, fpu_req_o, rvalid_o, rdata_o, rflags_o, rID_o, credits_o, overflow_o
  );

endinterface

// File: rtl/fpu_resp_fifo.sv
// Circular response FIFO; a push while full without a pop is dropped and flagged.
module fpu_resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  entry_t i_data,
  input  logic   i_pop,
  output entry_t o_head,
  output logic   o_empty,
  output logic   o_drop
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_wr;
  logic          w_rd;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  // A pop frees the slot the same cycle, so pushing into a full FIFO is legal then.
  assign w_wr    = i_push & (~w_full | i_pop);
  assign w_rd    = i_pop & ~o_empty;
  assign o_drop  = i_push & w_full & ~i_pop;
  assign o_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/fpu_resp_buffer.sv
// Credit-gated FPU request path with an in-order response buffer toward the consumer.
module fpu_resp_buffer
  import fpu_interco_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = RESP_ID_W,
  parameter int unsigned DATA_WIDTH      = RESP_DATA_W,
  parameter int unsigned FLAGS_OUT_WIDTH = RESP_FLAGS_W,
  parameter int unsigned DEPTH           = 4
) (
  input logic                clk,
  input logic                rst_n,
  fpu_resp_buffer_if.slave   io_bus
);
  localparam int unsigned     CW          = credit_width(DEPTH);
  localparam logic [CW-1:0]   MAX_CREDITS = CW'(DEPTH);

  logic [CW-1:0] r_credits;
  logic          r_overflow;
  logic          w_credit_ok;
  logic          w_issue;
  logic          w_pop;
  logic          w_empty;
  logic          w_drop;
  fpu_resp_t     w_push_data;
  fpu_resp_t     w_head;

  assign w_credit_ok      = (r_credits != '0);
  assign io_bus.fpu_req_o = io_bus.req_i & w_credit_ok;
  assign io_bus.gnt_o     = io_bus.fpu_gnt_i & w_credit_ok;
  assign w_issue          = io_bus.req_i & io_bus.fpu_gnt_i & w_credit_ok;
  assign w_pop            = ~w_empty & io_bus.rready_i;

  assign w_push_data.data  = io_bus.fpu_rdata_i;
  assign w_push_data.flags = io_bus.fpu_rflags_i;
  assign w_push_data.id    = io_bus.fpu_rID_i;

  fpu_resp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fpu_resp_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (io_bus.fpu_rvalid_i),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  // A pop at full credits means the consumer returned more than was issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_credits  <= MAX_CREDITS;
      r_overflow <= 1'b0;
    end else begin
      if (w_issue && !w_pop) begin
        r_credits <= r_credits - CW'(1);
      end else if (w_pop && !w_issue) begin
        if (r_credits == MAX_CREDITS) r_overflow <= 1'b1;
        else                          r_credits  <= r_credits + CW'(1);
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign io_bus.rvalid_o   = ~w_empty;
  assign io_bus.rdata_o    = w_head.data;
  assign io_bus.rflags_o   = w_head.flags;
  assign io_bus.rID_o      = w_head.id;
  assign io_bus.credits_o  = r_credits;
  assign io_bus.overflow_o = r_overflow;

endmodule

// File: tb/tb_fpu_resp_buffer.sv
// Bench for fpu_resp_buffer: queue-based reference model plus directed and random traffic.
module tb_fpu_resp_buffer;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  f;
    logic [8:0]  id;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   chk_en = 0;

  fpu_resp_buffer_if #(.DEPTH(4)) bus ();

  fpu_resp_buffer #(.DEPTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: state after the most recent clock edge, advanced at each negedge.
  ent_t m_q[$];
  int   m_credits = 4;
  bit   m_ovf     = 0;

  always @(negedge clk) begin
    bit   pop;
    bit   issue;
    ent_t e;
    if (chk_en) begin
      chk("rvalid", bus.rvalid_o, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("rdata", bus.rdata_o, m_q[0].d);
        chk("rflags", bus.rflags_o, m_q[0].f);
        chk("rID", bus.rID_o, m_q[0].id);
      end
      chk("credits", bus.credits_o, m_credits);
      chk("overflow", bus.overflow_o, m_ovf);
      chk("gnt", bus.gnt_o, bus.fpu_gnt_i & (m_credits != 0));
      chk("fpu_req", bus.fpu_req_o, bus.req_i & (m_credits != 0));
    end
    if (!rst_n) begin
      m_q.delete();
      m_credits = 4;
      m_ovf     = 0;
    end else begin
      pop   = (m_q.size() != 0) && bus.rready_i;
      issue = bus.req_i && bus.fpu_gnt_i && (m_credits != 0);
      if (issue && !pop) m_credits--;
      else if (pop && !issue) begin
        if (m_credits == 4) m_ovf = 1;
        else m_credits++;
      end
      if (bus.fpu_rvalid_i && m_q.size() == 4 && !pop) m_ovf = 1;
      else if (bus.fpu_rvalid_i) begin
        e = '{d: bus.fpu_rdata_i, f: bus.fpu_rflags_i, id: bus.fpu_rID_i};
        m_q.push_back(e);
      end
      if (pop) void'(m_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_resp(input bit v, input logic [8:0] id, input logic [31:0] d,
                          input logic [4:0] f);
    bus.fpu_rvalid_i = v;
    bus.fpu_rID_i    = id;
    bus.fpu_rdata_i  = d;
    bus.fpu_rflags_i = f;
  endtask

  logic [8:0] inflight[$];
  logic [8:0] tag;
  bit         iss_pend;
  bit         resp_pend;
  int         grants;

  initial begin
    rst_n        = 1'b0;
    bus.req_i    = 1'b0;
    bus.fpu_gnt_i = 1'b0;
    bus.rready_i = 1'b0;
    set_resp(0, '0, '0, '0);
    repeat (3) tick();
    rst_n  = 1'b1;
    chk_en = 1;
    #1;
    chk("rst_rvalid", bus.rvalid_o, 0);
    chk("rst_credits", bus.credits_o, 4);
    chk("rst_overflow", bus.overflow_o, 0);

    // Credits exhaust after DEPTH grants.
    bus.req_i     = 1'b1;
    bus.fpu_gnt_i = 1'b1;
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.gnt_o) grants++;
      tick();
    end
    chk("grant_count", grants, 4);
    #1;
    chk("gnt_exhausted", bus.gnt_o, 0);
    chk("fpu_req_exhausted", bus.fpu_req_o, 0);
    chk("credits_zero", bus.credits_o, 0);
    bus.req_i     = 1'b0;
    bus.fpu_gnt_i = 1'b0;

    // One-cycle registered latency, no bypass.
    tick();
    set_resp(1, 9'h005, 32'h3F800000, 5'h01);
    #1;
    chk("no_bypass", bus.rvalid_o, 0);
    tick();
    set_resp(0, '0, '0, '0);
    #1;
    chk("lat_rvalid", bus.rvalid_o, 1);
    chk("lat_rID", bus.rID_o, 9'h005);
    chk("lat_rdata", bus.rdata_o, 32'h3F800000);
    chk("lat_rflags", bus.rflags_o, 5'h01);

    // Fill to four, then push and pop together at full.
    for (int i = 0; i < 3; i++) begin
      set_resp(1, 9'(6 + i), 32'h40000000 + i, 5'(i));
      tick();
    end
    set_resp(0, '0, '0, '0);
    #1;
    chk("full_head", bus.rID_o, 9'h005);
    set_resp(1, 9'h009, 32'h40000003, 5'h03);
    bus.rready_i = 1'b1;
    tick();
    set_resp(0, '0, '0, '0);
    bus.rready_i = 1'b0;
    #1;
    chk("pushpop_head", bus.rID_o, 9'h006);
    chk("pushpop_ovf", bus.overflow_o, 0);

    // Extra beat into a full FIFO is dropped and flagged.
    set_resp(1, 9'h00A, 32'hDEADBEEF, 5'h1F);
    tick();
    set_resp(0, '0, '0, '0);
    #1;
    chk("drop_ovf", bus.overflow_o, 1);
    chk("drop_head_id", bus.rID_o, 9'h006);
    chk("drop_head_data", bus.rdata_o, 32'h40000000);
    bus.rready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_id", bus.rID_o, 9'(6 + i));
      tick();
      #1;
    end
    bus.rready_i = 1'b0;
    chk("drain_empty", bus.rvalid_o, 0);
    chk("ovf_sticky", bus.overflow_o, 1);
    chk("credits_sat", bus.credits_o, 4);

    // Reset mid-operation with three entries held and a beat arriving during reset.
    for (int i = 0; i < 3; i++) begin
      set_resp(1, 9'(9'h011 + i), 32'h50000000 + i, 5'h02);
      tick();
    end
    set_resp(0, '0, '0, '0);
    #1;
    chk("pre_rst_rvalid", bus.rvalid_o, 1);
    rst_n = 1'b0;
    set_resp(1, 9'h01F, 32'h12345678, 5'h04);
    tick();
    rst_n = 1'b1;
    set_resp(0, '0, '0, '0);
    bus.req_i     = 1'b1;
    bus.fpu_gnt_i = 1'b1;
    #1;
    chk("mid_rst_rvalid", bus.rvalid_o, 0);
    chk("mid_rst_credits", bus.credits_o, 4);
    chk("mid_rst_ovf", bus.overflow_o, 0);
    chk("post_rst_gnt", bus.gnt_o, 1);
    chk("post_rst_fpu_req", bus.fpu_req_o, 1);
    bus.req_i     = 1'b0;
    bus.fpu_gnt_i = 1'b0;
    tick();
    #1;
    chk("rst_beat_ignored", bus.rvalid_o, 0);

    // Random protocol-respecting traffic; FPU answers in order.
    tag       = '0;
    iss_pend  = 0;
    resp_pend = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (resp_pend) void'(inflight.pop_front());
      if (iss_pend) begin
        inflight.push_back(tag);
        tag = tag + 9'd1;
      end
      chk("conservation", int'(bus.credits_o) + m_q.size() + inflight.size(), 4);
      bus.req_i     = 1'($urandom_range(0, 1));
      bus.fpu_gnt_i = 1'($urandom_range(0, 1));
      bus.rready_i  = 1'($urandom_range(0, 2) != 0);
      if (inflight.size() != 0 && $urandom_range(0, 1) == 1)
        set_resp(1, inflight[0], 32'hA5000000 ^ 32'(inflight[0]), inflight[0][4:0]);
      else
        set_resp(0, '0, '0, '0);
      #1;
      iss_pend  = bus.req_i && bus.fpu_gnt_i && (m_credits != 0);
      resp_pend = bus.fpu_rvalid_i;
    end
    tick();
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
